// File: rtl/vd_frame_ctrl.sv
// Frame sequencer for the Viterbi(9) encode/decode pair: feeds payload and tail zeros to the
// encoder, times the decoder latency and captures decoded bits. Optional checker: VD_FRAME_CHECK_EN.
module vd_frame_ctrl #(
    parameter int FRAME_LEN = 18,
    parameter int TAIL_LEN  = 8,
    parameter int DEC_LAT   = 40
) (
    input  logic                             CLOCK,
    input  logic                             Reset,
    input  logic                             sym_tick,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic                             in_bit,
    output logic                             in_ready,
    output logic                             enc_bit,
    output logic                             dec_rst_n,
    output logic                             dec_active,
    input  logic                             dec_bit,
    output logic                             out_valid,
    output logic                             out_bit,
    output logic                             busy,
    output logic                             done,
    output logic                             underrun,
    output logic [$clog2(FRAME_LEN+1)-1:0]   err_count
);

    localparam int TW = $clog2(FRAME_LEN + DEC_LAT + 1);
    localparam int EW = $clog2(FRAME_LEN + 1);
    localparam logic [TW-1:0] LOAD_LAST_T = TW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_LAST_T = TW'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [TW-1:0] CAP_FIRST_T = TW'(DEC_LAT);
    localparam logic [TW-1:0] CAP_LAST_T  = TW'(FRAME_LEN + DEC_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TAIL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [TW-1:0] t_r;
    logic          start_s;
    logic          load_tick_s;
    logic          run_tick_s;
    logic          cap_s;
    logic          cap_last_s;
    logic          enc_bit_r;
    logic          dec_rst_n_r;
    logic          dec_active_r;
    logic          out_valid_r;
    logic          out_bit_r;
    logic          busy_r;
    logic          done_r;
    logic          underrun_r;

    assign start_s     = (state_r == ST_IDLE) && start;
    assign load_tick_s = (state_r == ST_LOAD) && sym_tick;
    assign run_tick_s  = sym_tick && ((state_r == ST_LOAD) || (state_r == ST_TAIL) ||
                                      (state_r == ST_DRAIN));
    // Decoded bit k appears DEC_LAT ticks after payload bit k was launched.
    assign cap_s       = run_tick_s && (t_r >= CAP_FIRST_T);
    assign cap_last_s  = cap_s && (t_r == CAP_LAST_T);

    assign in_ready   = load_tick_s;
    assign enc_bit    = enc_bit_r;
    assign dec_rst_n  = dec_rst_n_r;
    assign dec_active = dec_active_r;
    assign out_valid  = out_valid_r;
    assign out_bit    = out_bit_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign underrun   = underrun_r;

    // Next-state selection; the final capture wins over the phase boundaries.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cap_last_s) begin
                    state_nxt_s = ST_DONE;
                end else if (sym_tick && (t_r == LOAD_LAST_T)) begin
                    state_nxt_s = ST_TAIL;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_TAIL: begin
                if (cap_last_s) begin
                    state_nxt_s = ST_DONE;
                end else if (sym_tick && (t_r == TAIL_LAST_T)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_TAIL;
                end
            end
            ST_DRAIN: begin
                if (cap_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, tick counter and registered frame outputs.
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            t_r          <= {TW{1'b0}};
            enc_bit_r    <= 1'b0;
            dec_rst_n_r  <= 1'b1;
            dec_active_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_bit_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dec_rst_n_r  <= ~start_s;
            dec_active_r <= (state_nxt_s != ST_IDLE);
            busy_r       <= (state_nxt_s != ST_IDLE);
            done_r       <= (state_r == ST_DONE);
            out_valid_r  <= cap_s;
            if (cap_s) begin
                out_bit_r <= dec_bit;
            end
            if (start_s) begin
                t_r <= {TW{1'b0}};
            end else if (run_tick_s) begin
                t_r <= t_r + TW'(1);
            end
            // A missing payload bit is sent as zero so frame alignment never slips.
            if (load_tick_s) begin
                enc_bit_r <= in_valid & in_bit;
            end else if (run_tick_s) begin
                enc_bit_r <= 1'b0;
            end
            if (start_s) begin
                underrun_r <= 1'b0;
            end else if (load_tick_s && !in_valid) begin
                underrun_r <= 1'b1;
            end
        end
    end

`ifdef VD_FRAME_CHECK_EN
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FRAME_LEN-1:0] pay_r;
    logic [EW-1:0]        err_r;
    logic [IW-1:0]        load_idx_s;
    logic [IW-1:0]        cap_idx_s;
    logic                 mis_s;

    assign load_idx_s = IW'(t_r);
    assign cap_idx_s  = IW'(t_r - CAP_FIRST_T);
    assign mis_s      = dec_bit ^ pay_r[cap_idx_s];
    assign err_count  = err_r;

    // Payload store and decoded-vs-sent mismatch counter.
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            pay_r <= {FRAME_LEN{1'b0}};
            err_r <= {EW{1'b0}};
        end else begin
            if (start_s) begin
                err_r <= {EW{1'b0}};
            end else if (cap_s && mis_s) begin
                err_r <= err_r + EW'(1);
            end
            if (load_tick_s) begin
                pay_r[load_idx_s] <= in_valid & in_bit;
            end
        end
    end
`else
    assign err_count = {EW{1'b0}};
`endif

endmodule

// File: tb/tb_vd_frame_ctrl.sv
// Scoreboard bench for vd_frame_ctrl: directed frames through an ideal delay-line decoder model.
module tb_vd_frame_ctrl;

    localparam int FL = 18;
    localparam int TL = 8;
    localparam int DL = 40;
    localparam int EW = $clog2(FL + 1);
`ifdef VD_FRAME_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic          CLOCK;
    logic          Reset;
    logic          sym_tick;
    logic          start;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          enc_bit;
    logic          dec_rst_n;
    logic          dec_active;
    logic          dec_bit;
    logic          out_valid;
    logic          out_bit;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [EW-1:0] err_count;

    vd_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL)) dut (
        .CLOCK(CLOCK), .Reset(Reset), .sym_tick(sym_tick), .start(start),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .enc_bit(enc_bit),
        .dec_rst_n(dec_rst_n), .dec_active(dec_active), .dec_bit(dec_bit),
        .out_valid(out_valid), .out_bit(out_bit), .busy(busy), .done(done),
        .underrun(underrun), .err_count(err_count)
    );

    typedef struct {
        int err;
        bit und;
    } fexp_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    mon_cyc = 0;
    int    last_ov = 0;
    int    done_cnt = 0;
    int    tick_all = 0;
    int    tick_base = 0;
    int    ready_all = 0;
    int    ready_base = 0;
    bit    frame_on = 1'b0;
    bit    enc_hist [0:255];
    logic [FL-1:0] cur_pay;
    int    cur_drop = -1;
    int    cur_flip = -1;
    logic  exp_q [$];
    fexp_t frame_q [$];

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cur_tick();
        return tick_all - tick_base;
    endfunction

    // Encoder-side recorder: what the encoder samples on every symbol tick.
    always @(posedge CLOCK) begin
        if (sym_tick) begin
            if (frame_on && (cur_tick() >= 0) && (cur_tick() < 256)) begin
                enc_hist[cur_tick()] = enc_bit;
            end
            tick_all++;
        end
        if (in_ready) begin
            ready_all++;
        end
    end

    // One negedge of stimulus: tick strobe, payload offer and ideal decoder output.
    task automatic step();
        int k;
        @(negedge CLOCK);
        cyc++;
        sym_tick = ((cyc % 3) == 0);
        if (frame_on && sym_tick && (cur_tick() < FL)) begin
            in_valid = (cur_tick() != cur_drop);
            in_bit   = (cur_tick() == cur_drop) ? 1'b1 : cur_pay[FL-1-cur_tick()];
        end else begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
        end
        k = cur_tick() - DL;
        if (frame_on && (k >= 0) && (k < FL)) begin
            dec_bit = enc_hist[k+1] ^ (k == cur_flip);
        end else begin
            dec_bit = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on out_valid and the frame summary on done.
    always @(negedge CLOCK) begin
        fexp_t f;
        logic  e;
        bit    tz;
        mon_cyc++;
        if (Reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit", out_bit, e);
            end
            last_ov = mon_cyc;
        end
        if (Reset && done) begin
            if (frame_q.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                f = frame_q.pop_front();
                tz = 1'b0;
                for (int i = FL + 1; i <= FL + TL; i++) tz |= enc_hist[i];
                chk("done_tick", cur_tick(), FL + DL);
                chk("done_after_last_ov", mon_cyc - last_ov, 1);
                chk("err_count", err_count, f.err);
                chk("underrun", underrun, f.und);
                chk("outputs_pending", exp_q.size(), 0);
                chk("in_ready_ticks", ready_all - ready_base, FL);
                chk("tail_zero", tz, 1'b0);
            end
            done_cnt++;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_enc_bit"}, enc_bit, 1'b0);
        chk({tag, "_dec_rst_n"}, dec_rst_n, 1'b1);
        chk({tag, "_dec_active"}, dec_active, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_bit"}, out_bit, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic run_frame(input logic [FL-1:0] pay, input int drop, input int flip,
                             input bit coincide, input int mid_tick, input int abort_tick);
        int  exp_err;
        bit  exp_und;
        bit  b;
        bit  mid_done;
        bit  aborted;
        int  done_ref;
        exp_err  = 0;
        exp_und  = (drop >= 0);
        mid_done = 1'b0;
        aborted  = 1'b0;
        if (abort_tick < 0) begin
            for (int k = 0; k < FL; k++) begin
                b = pay[FL-1-k];
                if (k == drop) b = 1'b0;
                if (k == flip) begin
                    b = ~b;
                    exp_err = CHK;
                end
                exp_q.push_back(b);
            end
            frame_q.push_back('{exp_err, exp_und});
        end
        cur_pay  = pay;
        cur_drop = drop;
        cur_flip = flip;
        done_ref = done_cnt;
        do step(); while ((cyc % 3) != (coincide ? 0 : 1));
        start = 1'b1;
        step();
        start      = 1'b0;
        frame_on   = 1'b1;
        tick_base  = tick_all;
        ready_base = ready_all;
        chk("dec_rst_n_pulse", dec_rst_n, 1'b0);
        chk("busy_set", busy, 1'b1);
        chk("dec_active_set", dec_active, 1'b1);
        step();
        chk("dec_rst_n_release", dec_rst_n, 1'b1);
        for (int n = 0; n < 400 && done_cnt == done_ref && !aborted; n++) begin
            step();
            if (mid_tick >= 0 && !mid_done && cur_tick() == mid_tick && !sym_tick) begin
                start    = 1'b1;
                mid_done = 1'b1;
                step();
                start = 1'b0;
            end
            if (abort_tick >= 0 && cur_tick() == abort_tick) begin
                chk("busy_before_abort", busy, 1'b1);
                Reset = 1'b0;
                step();
                Reset = 1'b1;
                check_reset_state("abort");
                aborted = 1'b1;
            end
        end
        frame_on = 1'b0;
        if (!aborted) begin
            if (done_cnt == done_ref) begin
                chk("frame_timeout", done_cnt - done_ref, 1);
            end
            repeat (6) step();
            chk("idle_busy", busy, 1'b0);
            chk("idle_dec_active", dec_active, 1'b0);
            chk("hold_underrun", underrun, exp_und);
            chk("hold_err_count", err_count, exp_err);
        end
    endtask

    initial begin
        Reset    = 1'b0;
        start    = 1'b0;
        sym_tick = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        dec_bit  = 1'b0;
        repeat (4) step();
        check_reset_state("reset");
        Reset = 1'b1;
        repeat (3) step();
        // clean frame
        run_frame(18'b10_1011_0101_0101_1010, -1, -1, 1'b0, -1, -1);
        // underrun on tick 5, start coincident with a tick
        run_frame(18'b10_1011_0101_0101_1010, 5, -1, 1'b1, -1, -1);
        // decoder mismatch on bit 3, start pulsed mid-DRAIN
        run_frame(18'b11_0010_0111_0010_1101, -1, 3, 1'b0, 45, -1);
        // reset mid-TAIL after an underrun
        run_frame(18'b10_1011_0101_0101_1010, 2, -1, 1'b0, -1, 21);
        // full clean frame after the abort
        run_frame(18'b01_0100_1010_1010_0101, -1, -1, 1'b1, -1, -1);
        chk("done_pulses", done_cnt, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vd_frame_ctrl.md
# vd_frame_ctrl

Frame sequencer for the Viterbi(9) encode/decode path. It accepts a payload frame bit-serially and drives the encoder input, one bit per symbol tick. It then appends tail zeros to flush the K=9 encoder, holds the decoder active for its fixed latency, and captures the decoded frame. It sits between the stimulus/host side and the `viterbi_encode9` / `VITERBIDECODER` pair, replacing ad-hoc `X`/`Active`/`Reset` sequencing.

## Interface
Parameters:
- `FRAME_LEN`, 18: payload bits per frame, ≥1.
- `TAIL_LEN`, 8: flush zeros after payload (K−1).
- `DEC_LAT`, 40: decoder latency in symbol ticks, bit in → decoded bit out; must be ≥ `TAIL_LEN`.

Ports:
- `CLOCK` in 1: single clock. All logic on posedge.
- `Reset` in 1: synchronous, active-low reset.
- `sym_tick` in 1: one-cycle symbol-rate strobe. All frame progress happens only on cycles with `sym_tick`=1.
- `start` in 1: begin frame; honoured only in IDLE.
- `in_valid` in 1: payload bit offered.
- `in_bit` in 1: payload bit.
- `in_ready` out 1: `(state==LOAD) && sym_tick`.
- `enc_bit` out 1: registered encoder input `X`.
- `dec_rst_n` out 1: decoder reset, active low.
- `dec_active` out 1: decoder `Active`.
- `dec_bit` in 1: decoder `DecodeOut`.
- `out_valid` out 1: one-cycle pulse per decoded payload bit.
- `out_bit` out 1: decoded bit.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle end-of-frame pulse.
- `underrun` out 1: sticky; a LOAD tick arrived without `in_valid`.
- `err_count` out clog2(FRAME_LEN+1): decoded-vs-sent mismatches.

## Operation
- States: IDLE → LOAD → TAIL → DRAIN → DONE → IDLE.
- IDLE
  - `start`=1 → LOAD.
  - Clears tick counter `t`, `underrun`, `err_count`.
  - Drives `dec_rst_n`=0 for exactly that cycle.
- LOAD
  - On each tick: `enc_bit` ← `in_valid ? in_bit : 0`.
  - If `in_valid`=0 on a tick, set `underrun`; the payload bit is recorded as 0. Frame alignment is never stalled.
  - After `FRAME_LEN` ticks → TAIL.
- TAIL: `enc_bit` ← 0 for `TAIL_LEN` ticks → DRAIN.
- DRAIN: `enc_bit` held 0; remain until the last decoded bit is captured → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Capture
  - Tick index `t` starts at 0 on the first LOAD tick.
  - Payload bit k is launched at tick k. Decoded bit k is sampled from `dec_bit` at tick k+`DEC_LAT`, k = 0..FRAME_LEN−1.
  - Each sample produces `out_valid`=1 with `out_bit`=sample.
  - The last sample is at tick FRAME_LEN−1+DEC_LAT, after which → DONE. Because `DEC_LAT`≥`TAIL_LEN`, that tick falls in DRAIN, or on the final TAIL tick when `DEC_LAT`=`TAIL_LEN`.
- `dec_active`: 1 from the first LOAD cycle through DONE; 0 in IDLE.
- `start` while `busy` is ignored.
- `in_valid` outside LOAD is ignored.
- Counter widths: `t` is clog2(FRAME_LEN+DEC_LAT+1). `err_count` cannot overflow (≤ FRAME_LEN).

## Timing
- Reset values
  - State IDLE.
  - `enc_bit`=0, `dec_rst_n`=1, `dec_active`=0.
  - `out_valid`=0, `out_bit`=0, `done`=0, `busy`=0.
  - `underrun`=0, `err_count`=0.
- `Reset` low on any edge aborts the frame; outputs take reset values on the following cycle.
- `enc_bit` updates the cycle after the tick that produced it. The encoder samples it on the next tick.
- `out_valid`/`out_bit` are registered, asserting the cycle after the sampling tick.
- `done` asserts the cycle after the final `out_valid`.
- `start` and `sym_tick` in the same IDLE cycle: that tick is not a LOAD tick; LOAD begins on the next tick.
- `err_count` and `underrun` hold their values through IDLE until the next `start`.

## Configuration
- `VD_FRAME_CHECK_EN` defined
  - Payload bits are stored in a FRAME_LEN shift register.
  - Each captured bit is XORed with its stored bit; a mismatch increments `err_count` in the same cycle as `out_valid`.
- Undefined: no payload storage; `err_count` is tied to 0. All other behaviour is identical.

## Test plan
- Clean frame: FRAME_LEN=18, payload 18'b1_0101_1010_1_0101_1010, `in_valid` always 1, ideal decoder model with DEC_LAT=40 → 18 `out_valid` pulses equal to the payload; `err_count`=0; `done` one cycle after tick 57.
- Channel errors: 10 random single-bit flips on the encoder code into `VITERBIDECODER` → payload recovered; `err_count`=0 with `VD_FRAME_CHECK_EN`.
- Underrun: `in_valid` dropped on LOAD tick 5 → `underrun`=1; bit 5 sent as 0; frame length unchanged; `done` still after tick 57.
- Start-while-busy and start+tick coincidence: `start` pulsed mid-DRAIN is ignored. `start` with `sym_tick` in IDLE → first LOAD tick is the next tick.
- Reset mid-TAIL: `Reset`=0 for one cycle → all outputs at reset values next cycle. A new `start` runs a full clean frame.
- Macro off: forced decoder mismatch on bit 3 → `err_count` stays 0; `out_bit[3]` shows the mismatch.
